// File: rtl/phy_pkg.sv
// Shared PHY-lane definitions: symbol width, COM symbol, state encoding, LFSR constants.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package phy_pkg;

   localparam int          SYM_W     = 8;
   localparam logic [7:0]  COM_K28_5 = 8'hBC;
   localparam logic [15:0] LFSR_SEED = 16'hFFFF;
   // x^16+x^5+x^4+x^3+1 -> feedback into bits 5,4,3,0
   localparam logic [15:0] LFSR_TAPS = 16'h0039;

   typedef enum logic [1:0] {
      RST    = 2'd0,
      SYNC   = 2'd1,
      ACTIVE = 2'd2
   } state_e;

   // One Galois step, shifting towards the MSB; bit 15 is the keystream bit
   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return {s[14:0], 1'b0} ^ (s[15] ? LFSR_TAPS : 16'h0000);
   endfunction

endpackage

// File: rtl/par2ser_tx_if.sv
// Byte-in / bit-out bundle between the lane byte source and the serialiser.
// Latency: n/a (wires only).
// Backpressure: ready_out is a consume strobe; data_in/valid_in must be stable while it is high.
interface par2ser_tx_if;
   import phy_pkg::*;

   logic [SYM_W-1:0] data_in;
   logic             valid_in;
   logic             ready_out;
   logic             data_out;
   logic             active;

   modport master (output data_in, valid_in, input ready_out, data_out, active);
   modport slave  (input data_in, valid_in, output ready_out, data_out, active);

endinterface

// File: rtl/scrambler_lfsr16.sv
// 16-bit Galois keystream generator for data-symbol scrambling.
// Latency: key_bit reflects the current LFSR state; seed_ld/adv take effect at the next edge.
// Backpressure: none; seed_ld has priority over adv.
module scrambler_lfsr16
   import phy_pkg::*;
(
   input  logic clk_32f,
   input  logic reset,
   input  logic seed_ld,
   input  logic adv,
   output logic key_bit
);

   logic [15:0] lfsr_q;
   logic [15:0] lfsr_d;

   // Reseed on every COM, otherwise step once per scrambled bit
   always_comb begin
      lfsr_d = lfsr_q;
      if (seed_ld)
         lfsr_d = LFSR_SEED;
      else if (adv)
         lfsr_d = lfsr_step(lfsr_q);
   end

   // Keystream state register
   always_ff @(posedge clk_32f or negedge reset) begin
      if (!reset)
         lfsr_q <= LFSR_SEED;
      else
         lfsr_q <= lfsr_d;
   end

   assign key_bit = lfsr_q[15];

endmodule

// File: rtl/par2ser_tx.sv
// PCIe lane TX serialiser: 8-bit symbols out MSB first, COM sync burst after reset, COM idle fill.
// Latency: byte sampled in the ready_out cycle, its MSB on data_out the next cycle, LSB 7 cycles later.
// Backpressure: none downstream; upstream gets one ready_out strobe per 8 cycles in ACTIVE. Option: PAR2SER_SCRAMBLE_EN.
module par2ser_tx
   import phy_pkg::*;
#(
   parameter int          DATA_W    = SYM_W,
   parameter logic [7:0]  COM_SYM   = COM_K28_5,
   parameter int          SYNC_COMS = 4
)
(
   input  logic         clk_32f,
   input  logic         reset,
   par2ser_tx_if.slave  tx
);

   localparam logic [2:0] LAST_BIT  = 3'(DATA_W - 1);
   localparam logic [3:0] SYNC_LAST = 4'(SYNC_COMS);

   state_e            state_q,   state_d;
   logic [DATA_W-1:0] shift_q,   shift_d;
   logic [2:0]        bit_cnt_q, bit_cnt_d;
   logic [3:0]        com_cnt_q, com_cnt_d;
   logic              boundary;

   assign boundary = (bit_cnt_q == LAST_BIT);

   // Next-state: shift between boundaries, pick the next symbol at each boundary
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      com_cnt_d = com_cnt_q;
      case (state_q)
         RST: begin
            shift_d   = COM_SYM;
            bit_cnt_d = 3'd0;
            com_cnt_d = 4'd1;
            state_d   = (SYNC_COMS == 1) ? ACTIVE : SYNC;
         end
         SYNC: begin
            if (!boundary) begin
               shift_d   = {shift_q[DATA_W-2:0], 1'b0};
               bit_cnt_d = bit_cnt_q + 3'd1;
            end else begin
               shift_d   = COM_SYM;
               bit_cnt_d = 3'd0;
               com_cnt_d = com_cnt_q + 4'd1;
               // the COM loaded here is the last sync COM
               if (com_cnt_q + 4'd1 == SYNC_LAST)
                  state_d = ACTIVE;
            end
         end
         ACTIVE: begin
            // com_cnt_q holds its last value here; it has no role after sync
            if (!boundary) begin
               shift_d   = {shift_q[DATA_W-2:0], 1'b0};
               bit_cnt_d = bit_cnt_q + 3'd1;
            end else begin
               shift_d   = tx.valid_in ? tx.data_in : COM_SYM;
               bit_cnt_d = 3'd0;
            end
         end
         default: state_d = RST;
      endcase
   end

   // Serialiser state registers; reset drops any partial symbol
   always_ff @(posedge clk_32f or negedge reset) begin
      if (!reset) begin
         state_q   <= RST;
         shift_q   <= '0;
         bit_cnt_q <= 3'd0;
         com_cnt_q <= 4'd0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         com_cnt_q <= com_cnt_d;
      end
   end

   assign tx.active    = (state_q == ACTIVE);
   assign tx.ready_out = (state_q == ACTIVE) && boundary;

`ifdef PAR2SER_SCRAMBLE_EN
   logic com_ld;
   logic dat_ld;
   logic is_data_q;
   logic is_data_d;
   logic key_bit;

   assign com_ld = (state_q == RST)
                 || ((state_q == SYNC) && boundary)
                 || ((state_q == ACTIVE) && boundary && !tx.valid_in);
   assign dat_ld = (state_q == ACTIVE) && boundary && tx.valid_in;

   // Track whether the symbol currently on the wire is data (scrambled) or COM
   always_comb begin
      is_data_d = is_data_q;
      if (dat_ld)
         is_data_d = 1'b1;
      else if (com_ld)
         is_data_d = 1'b0;
   end

   // Data/COM flag register
   always_ff @(posedge clk_32f or negedge reset) begin
      if (!reset)
         is_data_q <= 1'b0;
      else
         is_data_q <= is_data_d;
   end

   scrambler_lfsr16 u_lfsr (
      .clk_32f (clk_32f),
      .reset   (reset),
      .seed_ld (com_ld),
      .adv     (is_data_q),
      .key_bit (key_bit)
   );

   assign tx.data_out = shift_q[DATA_W-1] ^ (is_data_q & key_bit);
`else
   assign tx.data_out = shift_q[DATA_W-1];
`endif

endmodule

// File: tb/tb_par2ser_tx.sv
// Directed bench for par2ser_tx: sync burst, single/back-to-back bytes, idle fill, mid-symbol reset, SYNC_COMS=1.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: bytes offered only in ready_out cycles, except where the bench tests otherwise.
module tb_par2ser_tx;

   logic clk_32f = 1'b0;
   logic reset   = 1'b1;
   int   n_chk   = 0;
   int   n_fail  = 0;
   logic [7:0] com_v = 8'hBC;

   par2ser_tx_if bus  ();
   par2ser_tx_if bus1 ();

   par2ser_tx #(.SYNC_COMS(4)) dut (
      .clk_32f (clk_32f),
      .reset   (reset),
      .tx      (bus)
   );

   par2ser_tx #(.SYNC_COMS(1)) dut1 (
      .clk_32f (clk_32f),
      .reset   (reset),
      .tx      (bus1)
   );

   always #5 clk_32f = ~clk_32f;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk_32f);
      #1;
   endtask

   task automatic release_reset();
      @(negedge clk_32f);
      reset = 1'b1;
   endtask

   // After release: 40 edges of COM pattern, active after e24, ready after e31 and e39
   task automatic check_sync(input string tag);
      logic exp_bit, exp_act, exp_rdy;
      for (int k = 0; k < 40; k++) begin
         tick();
         exp_bit = com_v[7 - (k % 8)];
         exp_act = (k >= 24);
         exp_rdy = (k >= 31) && ((k % 8) == 7);
         n_chk++;
         if (bus.data_out !== exp_bit) begin
            n_fail++;
            $display("FAIL %s data_out e%0d: got %b want %b", tag, k, bus.data_out, exp_bit);
         end
         n_chk++;
         if (bus.active !== exp_act) begin
            n_fail++;
            $display("FAIL %s active e%0d: got %b want %b", tag, k, bus.active, exp_act);
         end
         n_chk++;
         if (bus.ready_out !== exp_rdy) begin
            n_fail++;
            $display("FAIL %s ready_out e%0d: got %b want %b", tag, k, bus.ready_out, exp_rdy);
         end
      end
   endtask

   task automatic wait_ready(input string tag);
      int n = 0;
      while (!bus.ready_out && n < 16) begin
         tick();
         n++;
      end
      n_chk++;
      if (bus.ready_out !== 1'b1) begin
         n_fail++;
         $display("FAIL %s wait_ready timeout: ready_out=%b want 1", tag, bus.ready_out);
      end
   endtask

   // Offer b in the current ready cycle, check its 8 bits; ends on the next ready cycle
   task automatic send_byte(input logic [7:0] b, input string tag);
      bus.data_in  = b;
      bus.valid_in = 1'b1;
      for (int i = 7; i >= 0; i--) begin
         tick();
         if (i == 7) begin
            bus.valid_in = 1'b0;
            bus.data_in  = 8'h00;
         end
         n_chk++;
         if (bus.data_out !== b[i]) begin
            n_fail++;
            $display("FAIL %s bit%0d: got %b want %b", tag, i, bus.data_out, b[i]);
         end
         n_chk++;
         if (bus.ready_out !== (i == 0)) begin
            n_fail++;
            $display("FAIL %s ready_out at bit%0d: got %b want %b", tag, i, bus.ready_out, (i == 0));
         end
      end
   endtask

   task automatic expect_com(input string tag);
      for (int i = 7; i >= 0; i--) begin
         tick();
         n_chk++;
         if (bus.data_out !== com_v[i]) begin
            n_fail++;
            $display("FAIL %s com bit%0d: got %b want %b", tag, i, bus.data_out, com_v[i]);
         end
      end
   endtask

   task automatic test_reset();
      bus.valid_in  = 1'b0;
      bus.data_in   = 8'h00;
      bus1.valid_in = 1'b0;
      bus1.data_in  = 8'h00;
      #2 reset = 1'b0;
      #3;
      n_chk++;
      if ({bus.data_out, bus.ready_out, bus.active} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset outputs: got %b want 000", {bus.data_out, bus.ready_out, bus.active});
      end
      repeat (2) tick();
      release_reset();
      check_sync("sync");
   endtask

   task automatic test_single_byte();
      wait_ready("a5");
      send_byte(8'hA5, "a5");
      expect_com("a5_idle");
   endtask

   // valid_in raised and dropped between ready cycles must not be consumed
   task automatic test_nonready_valid();
      wait_ready("nrv");
      tick();
      bus.data_in  = 8'h55;
      bus.valid_in = 1'b1;
      repeat (6) begin
         tick();
         n_chk++;
         if (bus.ready_out !== 1'b0) begin
            n_fail++;
            $display("FAIL nrv ready_out: got %b want 0", bus.ready_out);
         end
      end
      bus.valid_in = 1'b0;
      tick();
      expect_com("nrv");
   endtask

   task automatic test_back_to_back();
      wait_ready("b2b");
      send_byte(8'h00, "b2b_00");
      send_byte(8'hFF, "b2b_ff");
      send_byte(8'h3C, "b2b_3c");
      expect_com("b2b_idle");
   endtask

   task automatic test_reset_mid();
      wait_ready("rmid");
      bus.data_in  = 8'hF0;
      bus.valid_in = 1'b1;
      tick();
      bus.valid_in = 1'b0;
      repeat (3) tick();
      n_chk++;
      if ({bus.data_out, bus.active} !== 2'b11) begin
         n_fail++;
         $display("FAIL rmid pre-reset {data_out,active}: got %b want 11", {bus.data_out, bus.active});
      end
      #2 reset = 1'b0;
      #1;
      n_chk++;
      if ({bus.data_out, bus.ready_out, bus.active} !== 3'b000) begin
         n_fail++;
         $display("FAIL rmid async clear: got %b want 000", {bus.data_out, bus.ready_out, bus.active});
      end
      repeat (3) tick();
      release_reset();
      check_sync("rmid_sync");
   endtask

   task automatic test_sync_one();
      #2 reset = 1'b0;
      repeat (2) tick();
      n_chk++;
      if ({bus1.data_out, bus1.ready_out, bus1.active} !== 3'b000) begin
         n_fail++;
         $display("FAIL sync1 reset: got %b want 000", {bus1.data_out, bus1.ready_out, bus1.active});
      end
      release_reset();
      for (int k = 0; k < 16; k++) begin
         tick();
         n_chk++;
         if (bus1.active !== 1'b1) begin
            n_fail++;
            $display("FAIL sync1 active e%0d: got %b want 1", k, bus1.active);
         end
         n_chk++;
         if (bus1.ready_out !== ((k % 8) == 7)) begin
            n_fail++;
            $display("FAIL sync1 ready_out e%0d: got %b want %b", k, bus1.ready_out, ((k % 8) == 7));
         end
         n_chk++;
         if (bus1.data_out !== com_v[7 - (k % 8)]) begin
            n_fail++;
            $display("FAIL sync1 data_out e%0d: got %b want %b", k, bus1.data_out, com_v[7 - (k % 8)]);
         end
      end
   endtask

`ifdef PAR2SER_SCRAMBLE_EN
   // 8'h00 after a COM shows the raw keystream from the seed, identical each time
   task automatic test_scramble();
      logic [15:0] l;
      logic        exp_bit;
      for (int rep = 0; rep < 2; rep++) begin
         wait_ready("scr");
         bus.data_in  = 8'h00;
         bus.valid_in = 1'b1;
         l = 16'hFFFF;
         for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 0) bus.valid_in = 1'b0;
            exp_bit = l[15];
            n_chk++;
            if (bus.data_out !== exp_bit) begin
               n_fail++;
               $display("FAIL scr rep%0d bit%0d: got %b want %b", rep, i, bus.data_out, exp_bit);
            end
            l = {l[14:0], 1'b0} ^ (l[15] ? 16'h0039 : 16'h0000);
         end
         expect_com("scr_com");
      end
   endtask
`endif

   initial begin
      test_reset();
`ifdef PAR2SER_SCRAMBLE_EN
      test_scramble();
`else
      test_single_byte();
      test_nonready_valid();
      test_back_to_back();
      test_reset_mid();
`endif
      test_sync_one();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/par2ser_tx.md
Name: par2ser_tx

Overview:
- Transmit parallel-to-serial stage of the PCIe PHY lane.
- Runs on the fastest clock, clk_32f, the same clock the lane clock divider takes as input. That divider's clk_4f-rate byte stream arrives here already resynchronised to clk_32f as one byte per 8 cycles.
- Serialises 8-bit symbols MSB first.
- Inserts COM (K28.5, 8'hBC) symbols for link sync after reset and as idle fill.

Parameters:
- DATA_W, 8: symbol width. Fixed at 8; the parameter exists only for package consistency.
- COM_SYM, 8'hBC: idle/sync symbol.
- SYNC_COMS, 4: COM symbols sent before data is accepted. Legal range 1..15.

Ports:
- clk_32f  in  1  serial bit clock; all logic on posedge.
- reset  in  1  asynchronous, active-low reset (reset==0 clears all state immediately).
- data_in  in  8  byte to transmit; sampled only when ready_out && valid_in.
- valid_in  in  1  data_in holds a valid byte.
- ready_out  out  1  byte-consume strobe; high exactly one cycle per 8 in ACTIVE.
- data_out  out  1  serial bit = shift_reg[7] (XOR keystream when the optional feature is on).
- active  out  1  high while state==ACTIVE.

Behaviour:
- Reset (reset==0, asynchronous):
  - shift_reg=0, bit_cnt=0, com_cnt=0, state=RST.
  - Outputs: data_out=0, ready_out=0, active=0.
- States: RST -> SYNC -> ACTIVE. No path back except reset.
- RST: first posedge after reset release.
  - Load COM_SYM; bit_cnt<=0; com_cnt<=1.
  - Next state is SYNC, or ACTIVE if SYNC_COMS==1.
- Shifting:
  - Every posedge with bit_cnt!=7: shift_reg<=shift_reg<<1; bit_cnt<=bit_cnt+1.
  - Posedge with bit_cnt==7 is a reload boundary: load a new symbol; bit_cnt<=0 (3-bit wrap).
- SYNC reload:
  - Load COM_SYM; com_cnt<=com_cnt+1.
  - If com_cnt+1==SYNC_COMS, move to ACTIVE. The COM loaded at that boundary is the last sync COM.
  - data_in is ignored and ready_out is 0 throughout SYNC.
- ACTIVE:
  - ready_out = (bit_cnt==7), combinational.
  - At the boundary: load data_in if valid_in, else COM_SYM (idle fill).
  - valid_in is don't-care when ready_out=0. Upstream must hold data_in/valid_in stable through the ready cycle.
- Latency: byte sampled at the ready_out cycle; its MSB appears on data_out the next cycle; LSB 7 cycles later.
- Timing with SYNC_COMS=4:
  - Release edge e0 loads COM#1; COM#4 loads at e24 (enter ACTIVE).
  - First ready_out is the cycle after e31; first data MSB appears after e32.
- Simultaneous events:
  - valid_in rising on a non-ready cycle: no effect until the next ready cycle.
  - Reset asserted mid-symbol: partial symbol is dropped, all state clears, sync restarts from RST.
- data_in==COM_SYM with valid_in=1: transmitted as COM (indistinguishable from idle).
- com_cnt saturates once ACTIVE and is unused there.

Optional Feature:
- Macro: PAR2SER_SCRAMBLE_EN.
- Defined:
  - 16-bit Galois LFSR, polynomial x^16+x^5+x^4+x^3+1, seed 16'hFFFF.
  - LFSR resets to seed on every COM load.
  - LFSR advances one step per transmitted bit of data (non-COM) symbols only.
  - data_out = shift_reg[7] ^ lfsr[15] for data symbols; COM bits are sent unscrambled.
  - Reset value of lfsr is 16'hFFFF.
- Undefined: no LFSR logic; data_out = shift_reg[7].

Decomposition:
- Shared package phy_pkg:
  - COM_K28_5 = 8'hBC.
  - State encoding RST=2'd0, SYNC=2'd1, ACTIVE=2'd2.
  - LFSR_SEED = 16'hFFFF, LFSR_TAPS = 16'h0039.
- One sub-module, scrambler_lfsr16 (ports: clk_32f, reset, seed_ld, adv, key_bit). Instantiated only under PAR2SER_SCRAMBLE_EN.

Test Plan:
- Reset release, valid_in=0 for 64 cycles -> data_out repeats 10111100 from cycle 1; active rises after e24; ready_out pulses after e31, e39, e47…
- ACTIVE, valid_in=1 with data_in=8'hA5 at the first ready cycle -> the next 8 data_out bits are 1,0,1,0,0,1,0,1, then COM (valid dropped).
- Back-to-back bytes 8'h00, 8'hFF, 8'h3C on consecutive ready cycles -> 24 contiguous bits 00000000 11111111 00111100 with no gaps.
- Reset asserted at bit 3 of a data byte -> data_out, ready_out and active go 0 immediately; after release the full 4-COM sync repeats before the next ready.
- SYNC_COMS=1 -> ACTIVE immediately after e0; first ready_out after e7.
- PAR2SER_SCRAMBLE_EN defined, byte 8'h00 sent right after a COM -> first data_out bit = 1 (lfsr[15] of seed). COM bits are unaltered. The keystream restarts identically after each COM.
